riscv_v_exe_wb_buffer: RTL and testbench

//  Decoupling buffer between the vector EXE ALU and the writeback stage. Captures per-op vector,

---
 rtl/riscv_v_exe_wb_buffer.sv | 112 +++++++++++
 tb/tb_riscv_v_exe_wb_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_exe_wb_buffer.sv
// riscv_v_exe_wb_buffer: EXE-to-writeback result FIFO with pending-vreg bitmap and retire counter
module riscv_v_exe_wb_buffer #(
  parameter int DATA_W = 128,
  parameter int INT_W = 32,
  parameter int MASK_W = 16,
  parameter int NUM_VREG = 32,
  parameter int DEPTH = 2,
  localparam int VREG_W = $clog2(NUM_VREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                valid_exe,
  output logic                ready_exe,
  input  logic [DATA_W-1:0]   vec_result_exe,
  input  logic [INT_W-1:0]    int_result_exe,
  input  logic [MASK_W-1:0]   mask_result_exe,
  input  logic [DATA_W/8-1:0] vec_be_exe,
  input  logic [VREG_W-1:0]   vdst_exe,
  input  logic [4:0]          rd_exe,
  input  logic                we_vec_exe,
  input  logic                we_int_exe,
  input  logic                we_mask_exe,
  output logic                valid_wb,
  input  logic                ready_wb,
  output logic [DATA_W-1:0]   vec_result_wb,
  output logic [INT_W-1:0]    int_result_wb,
  output logic [MASK_W-1:0]   mask_result_wb,
  output logic [DATA_W/8-1:0] vec_be_wb,
  output logic [VREG_W-1:0]   vdst_wb,
  output logic [4:0]          rd_wb,
  output logic                we_vec_wb,
  output logic                we_int_wb,
  output logic                we_mask_wb,
  output logic [NUM_VREG-1:0] pending_vreg,
  output logic [31:0]         retire_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_W-1:0]   vec;
    logic [INT_W-1:0]    ires;
    logic [MASK_W-1:0]   mres;
    logic [DATA_W/8-1:0] be;
    logic [VREG_W-1:0]   vdst;
    logic [4:0]          rd;
    logic                wv;
    logic                wi;
    logic                wm;
  } ent_t;
  ent_t mem [DEPTH];
  ent_t din, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] occ, occ_n;
  logic push, pop;
  assign ready_exe = count != CNT_W'(DEPTH);
  assign valid_wb = count != '0;
  assign push = valid_exe & ready_exe & ~flush;
  assign pop = valid_wb & ready_wb;
  assign din = '{vec: vec_result_exe, ires: int_result_exe, mres: mask_result_exe, be: vec_be_exe,
                 vdst: vdst_exe, rd: rd_exe, wv: we_vec_exe, wi: we_int_exe, wm: we_mask_exe};
  // Zero when empty so downstream can OR-merge writeback sources.
  assign head = valid_wb ? mem[rd_ptr] : '0;
  assign vec_result_wb = head.vec;
  assign int_result_wb = head.ires;
  assign mask_result_wb = head.mres;
  assign vec_be_wb = head.be;
  assign vdst_wb = head.vdst;
  assign rd_wb = head.rd;
  assign we_vec_wb = head.wv;
  assign we_int_wb = head.wi;
  assign we_mask_wb = head.wm;
  always_comb begin
    occ_n = occ;
    if (pop) occ_n[rd_ptr] = 1'b0;
    if (push) occ_n[wr_ptr] = 1'b1;
  end
  always_comb begin
    pending_vreg = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (occ[e] && mem[e].wv) pending_vreg[mem[e].vdst] = 1'b1;
      if (occ[e] && mem[e].wm) pending_vreg[0] = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      occ <= '0;
      retire_cnt <= '0;
    end else begin
      if (pop) retire_cnt <= retire_cnt + 32'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        occ <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        occ <= occ_n;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && count == CNT_W'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) valid_wb && !ready_wb && !flush |=> $stable(head));
endmodule

// File: tb/tb_riscv_v_exe_wb_buffer.sv
// tb_riscv_v_exe_wb_buffer: randomized self-checking bench against a queue-based model
module tb_riscv_v_exe_wb_buffer;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [127:0] vec;
    logic [31:0]  ires;
    logic [15:0]  mres;
    logic [15:0]  be;
    logic [4:0]   vdst;
    logic [4:0]   rd;
    logic         wv;
    logic         wi;
    logic         wm;
  } ent_t;
  logic clk = 0, rst = 0, flush = 0, valid_exe = 0, ready_wb = 0;
  ent_t din = '0;
  ent_t obs;
  logic ready_exe, valid_wb;
  logic [127:0] vec_result_wb;
  logic [31:0] int_result_wb, retire_cnt;
  logic [15:0] mask_result_wb, vec_be_wb;
  logic [4:0] vdst_wb, rd_wb;
  logic we_vec_wb, we_int_wb, we_mask_wb;
  logic [31:0] pending_vreg;
  ent_t q[$];
  logic [31:0] rc = 0;
  bit acc;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  riscv_v_exe_wb_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_exe(valid_exe), .ready_exe(ready_exe),
    .vec_result_exe(din.vec), .int_result_exe(din.ires), .mask_result_exe(din.mres),
    .vec_be_exe(din.be), .vdst_exe(din.vdst), .rd_exe(din.rd), .we_vec_exe(din.wv),
    .we_int_exe(din.wi), .we_mask_exe(din.wm), .valid_wb(valid_wb), .ready_wb(ready_wb),
    .vec_result_wb(vec_result_wb), .int_result_wb(int_result_wb), .mask_result_wb(mask_result_wb),
    .vec_be_wb(vec_be_wb), .vdst_wb(vdst_wb), .rd_wb(rd_wb), .we_vec_wb(we_vec_wb),
    .we_int_wb(we_int_wb), .we_mask_wb(we_mask_wb), .pending_vreg(pending_vreg),
    .retire_cnt(retire_cnt)
  );
  assign obs = {vec_result_wb, int_result_wb, mask_result_wb, vec_be_wb, vdst_wb, rd_wb,
                we_vec_wb, we_int_wb, we_mask_wb};
  function automatic ent_t rand_ent();
    ent_t e;
    e.vec = {$urandom, $urandom, $urandom, $urandom};
    e.ires = $urandom;
    e.mres = 16'($urandom);
    e.be = 16'($urandom);
    e.vdst = 5'($urandom);
    e.rd = 5'($urandom);
    e.wv = 1'($urandom);
    e.wi = 1'($urandom);
    e.wm = 1'($urandom);
    return e;
  endfunction
  function automatic ent_t exp_head();
    return q.size() != 0 ? q[0] : '0;
  endfunction
  function automatic logic [31:0] exp_pend();
    logic [31:0] p = '0;
    foreach (q[i]) begin
      if (q[i].wv) p[q[i].vdst] = 1'b1;
      if (q[i].wm) p[0] = 1'b1;
    end
    return p;
  endfunction
  task automatic tick();
    bit do_pop, do_push;
    @(posedge clk);
    acc = 0;
    do_pop = q.size() != 0 && ready_wb;
    do_push = valid_exe && q.size() != DEPTH && !flush;
    if (rst) begin
      q.delete();
      rc = 0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        rc = rc + 1;
      end
      if (flush) q.delete();
      else if (do_push) begin
        q.push_back(din);
        acc = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1;
    valid_exe = 1;
    din = rand_ent();
    tick();
    rst = 0;
    valid_exe = 0;
    n_chk += 5;
    if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL reset_valid_wb: got %b expected 0", valid_wb); end
    if (ready_exe !== 1'b1) begin n_fail++; $display("FAIL reset_ready_exe: got %b expected 1", ready_exe); end
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    if (pending_vreg !== '0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", pending_vreg); end
    if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_retire: got %h expected 0", retire_cnt); end
  endtask
  task automatic test_single();
    ent_t e = '0;
    e.vec = {16{8'hA5}};
    e.vdst = 5'd3;
    e.wv = 1'b1;
    din = e;
    valid_exe = 1;
    ready_wb = 1;
    tick();
    valid_exe = 0;
    n_chk += 3;
    if (valid_wb !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid_wb); end
    if (obs !== e) begin n_fail++; $display("FAIL single_data: got %h expected %h", obs, e); end
    if (pending_vreg !== 32'h8) begin n_fail++; $display("FAIL single_pending: got %h expected 8", pending_vreg); end
    tick();
    n_chk += 2;
    if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL single_retire: got %0d expected 1", retire_cnt); end
    if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", valid_wb); end
  endtask
  task automatic test_back_to_back();
    ent_t items[3];
    int k = 0, o = 0;
    logic [31:0] rc0 = retire_cnt;
    foreach (items[i]) items[i] = rand_ent();
    ready_wb = 0;
    valid_exe = 1;
    for (int i = 0; i < 3; i++) begin
      din = items[k];
      tick();
      if (acc) k++;
    end
    n_chk += 3;
    if (ready_exe !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", ready_exe); end
    if (valid_wb !== 1'b1) begin n_fail++; $display("FAIL b2b_full_valid: got %b expected 1", valid_wb); end
    if (obs !== items[0]) begin n_fail++; $display("FAIL b2b_head_hold: got %h expected %h", obs, items[0]); end
    ready_wb = 1;
    for (int i = 0; i < 10; i++) begin
      valid_exe = k < 3;
      din = k < 3 ? items[k] : '0;
      if (i == 0) begin
        n_chk++;
        if (ready_exe !== 1'b0) begin n_fail++; $display("FAIL full_pop_only_ready: got %b expected 0", ready_exe); end
      end
      if (valid_wb === 1'b1) begin
        n_chk++;
        if (o >= 3) begin n_fail++; $display("FAIL b2b_extra: got %h expected none", obs); end
        else if (obs !== items[o]) begin n_fail++; $display("FAIL b2b_order%0d: got %h expected %h", o, obs, items[o]); end
        o++;
      end
      tick();
      if (acc) k++;
    end
    valid_exe = 0;
    n_chk += 2;
    if (o != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", o); end
    if (retire_cnt !== rc0 + 3) begin n_fail++; $display("FAIL b2b_retire: got %0d expected %0d", retire_cnt, rc0 + 3); end
  endtask
  task automatic test_pending();
    ent_t a = rand_ent(), b = rand_ent();
    a.wv = 1; a.wm = 0; a.vdst = 5'd5;
    b.wv = 0; b.wm = 1;
    ready_wb = 0;
    valid_exe = 1;
    din = a;
    tick();
    din = b;
    n_chk++;
    if (pending_vreg !== 32'h20) begin n_fail++; $display("FAIL pend_excl_push: got %h expected 20", pending_vreg); end
    tick();
    valid_exe = 0;
    n_chk++;
    if (pending_vreg !== 32'h21) begin n_fail++; $display("FAIL pend_both: got %h expected 21", pending_vreg); end
    ready_wb = 1;
    tick();
    n_chk++;
    if (pending_vreg !== 32'h01) begin n_fail++; $display("FAIL pend_one: got %h expected 01", pending_vreg); end
    tick();
    n_chk++;
    if (pending_vreg !== 32'h0) begin n_fail++; $display("FAIL pend_none: got %h expected 0", pending_vreg); end
  endtask
  task automatic test_flush();
    logic [31:0] rc0;
    ready_wb = 0;
    valid_exe = 1;
    for (int i = 0; i < 2; i++) begin
      din = rand_ent();
      din.wv = 1;
      tick();
    end
    rc0 = retire_cnt;
    din = rand_ent();
    flush = 1;
    tick();
    flush = 0;
    valid_exe = 0;
    n_chk += 5;
    if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_wb); end
    if (pending_vreg !== '0) begin n_fail++; $display("FAIL flush_pending: got %h expected 0", pending_vreg); end
    if (ready_exe !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", ready_exe); end
    if (obs !== '0) begin n_fail++; $display("FAIL flush_outputs: got %h expected 0", obs); end
    if (retire_cnt !== rc0) begin n_fail++; $display("FAIL flush_retire: got %0d expected %0d", retire_cnt, rc0); end
    valid_exe = 1;
    din = rand_ent();
    tick();
    valid_exe = 0;
    ready_wb = 1;
    flush = 1;
    tick();
    flush = 0;
    n_chk += 2;
    if (retire_cnt !== rc0 + 1) begin n_fail++; $display("FAIL flush_pop_retire: got %0d expected %0d", retire_cnt, rc0 + 1); end
    if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL flush_pop_valid: got %b expected 0", valid_wb); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_exe = 1'($urandom);
      ready_wb = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      din = rand_ent();
      n_chk += 5;
      if (obs !== exp_head()) begin n_fail++; $display("FAIL rnd_head@%0d: got %h expected %h", i, obs, exp_head()); end
      if (ready_exe !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", i, ready_exe, q.size() != DEPTH); end
      if (valid_wb !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, valid_wb, q.size() != 0); end
      if (pending_vreg !== exp_pend()) begin n_fail++; $display("FAIL rnd_pending@%0d: got %h expected %h", i, pending_vreg, exp_pend()); end
      if (retire_cnt !== rc) begin n_fail++; $display("FAIL rnd_retire@%0d: got %0d expected %0d", i, retire_cnt, rc); end
      tick();
    end
    flush = 0;
    valid_exe = 0;
  endtask
  task automatic test_wrap_and_reset();
    ready_wb = 0;
    valid_exe = 1;
    din = rand_ent();
    tick();
    valid_exe = 0;
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    rc = 32'hFFFF_FFFF;
    n_chk++;
    if (retire_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffffffff", retire_cnt); end
    ready_wb = 1;
    tick();
    n_chk++;
    if (retire_cnt !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", retire_cnt); end
    ready_wb = 0;
    valid_exe = 1;
    for (int i = 0; i < 2; i++) begin
      din = rand_ent();
      din.wv = 1;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    valid_exe = 0;
    n_chk += 5;
    if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid_wb); end
    if (ready_exe !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready_exe); end
    if (obs !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 0", obs); end
    if (pending_vreg !== '0) begin n_fail++; $display("FAIL midrst_pending: got %h expected 0", pending_vreg); end
    if (retire_cnt !== '0) begin n_fail++; $display("FAIL midrst_retire: got %h expected 0", retire_cnt); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_pending();
    test_flush();
    test_random();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
